// File: rtl/fetch_buffer_pkg.sv
// Shared types for the fetch buffer: RV32I word and the per-entry record.
// Optional same-cycle bypass is enabled by defining FETCH_BUFFER_BYPASS_EN.
package fetch_buffer_pkg;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    rv32i_word instr;
    rv32i_word pc;
    logic      under_shadow;
  } fb_entry_t;

  localparam int FB_DEFAULT_DEPTH = 8;

endpackage

// File: rtl/fetch_buffer_ptr.sv
// Wrap-bit circular pointer with increment and clear, used for head and tail.
// The extra MSB distinguishes full from empty when the index bits coincide.
module fb_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Clear takes priority over increment so a redirect always lands at zero
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_buffer.sv
// Decoupling FIFO between fetch and decode with single-cycle flush.
// Define FETCH_BUFFER_BYPASS_EN for a zero-latency empty-buffer bypass.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FB_DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [31:0]              push_instr,
  input  logic [31:0]              push_pc,
  input  logic                     push_under_shadow,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [31:0]              pop_instr,
  output logic [31:0]              pop_pc,
  output logic                     pop_under_shadow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int PTRW = IDXW + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gDepthCheck
      $error("fetch_buffer: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  fb_entry_t       storage_q [DEPTH];
  logic [PTRW-1:0] headPtr;
  logic [PTRW-1:0] tailPtr;
  logic [IDXW-1:0] headIdx;
  logic [IDXW-1:0] tailIdx;
  logic            empty;
  logic            full;
  logic            bypass;
  logic            pushFire;
  logic            popFire;
  logic            writeEn;
  logic            headInc;
  fb_entry_t       pushEntry;
  fb_entry_t       popEntry;

  assign headIdx = headPtr[IDXW-1:0];
  assign tailIdx = tailPtr[IDXW-1:0];
  assign empty   = (headPtr == tailPtr);
  assign full    = (headIdx == tailIdx) && (headPtr[IDXW] != tailPtr[IDXW]);

  assign pushEntry = '{instr: push_instr, pc: push_pc, under_shadow: push_under_shadow};

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass = empty && push_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push_ready = !full;
  assign pop_valid  = !empty || bypass;
  assign popEntry   = bypass ? pushEntry : storage_q[headIdx];

  assign pop_instr        = popEntry.instr;
  assign pop_pc           = popEntry.pc;
  assign pop_under_shadow = popEntry.under_shadow;

  assign pushFire = push_valid && push_ready;
  assign popFire  = pop_valid && pop_ready;

  // A bypassed entry that decode takes immediately never touches storage
  assign writeEn = pushFire && !flush && !(bypass && pop_ready);
  assign headInc = popFire && !flush && !bypass;

  fb_ptr #(.W(PTRW)) uHeadPtr (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .inc_i   (headInc),
    .ptr_o   (headPtr)
  );

  fb_ptr #(.W(PTRW)) uTailPtr (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .inc_i   (writeEn),
    .ptr_o   (tailPtr)
  );

  // Only slot 0 is cleared so the head outputs read zero straight after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      storage_q[0] <= '0;
    end else if (writeEn) begin
      storage_q[tailIdx] <= pushEntry;
    end
  end

  assign count = tailPtr - headPtr;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and randomized self-checking bench for fetch_buffer (default build).
module tb_fetch_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_instr;
  logic [31:0] push_pc;
  logic        push_under_shadow;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_instr;
  logic [31:0] pop_pc;
  logic        pop_under_shadow;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_buffer #(.DEPTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .push_valid        (push_valid),
    .push_ready        (push_ready),
    .push_instr        (push_instr),
    .push_pc           (push_pc),
    .push_under_shadow (push_under_shadow),
    .pop_valid         (pop_valid),
    .pop_ready         (pop_ready),
    .pop_instr         (pop_instr),
    .pop_pc            (pop_pc),
    .pop_under_shadow  (pop_under_shadow),
    .count             (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    rst = 0; flush = 0; push_valid = 0; pop_ready = 0;
    push_instr = '0; push_pc = '0; push_under_shadow = 0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_push_ready got %b want 1", push_ready); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pop_valid got %b want 0", pop_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    checks++; if (pop_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_pop_instr got %h want 0", pop_instr); end
    checks++; if (pop_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pop_pc got %h want 0", pop_pc); end
    checks++; if (pop_under_shadow !== 1'b0) begin errors++; $display("[TB] FAIL reset_pop_shadow got %b want 0", pop_under_shadow); end
  endtask

  task automatic test_single_push();
    logic expSame;
`ifdef FETCH_BUFFER_BYPASS_EN
    expSame = 1'b1;
`else
    expSame = 1'b0;
`endif
    push_valid = 1; push_instr = 32'h00500093; push_pc = 32'h100; push_under_shadow = 1;
    pop_ready = 0;
    #1;
    checks++; if (pop_valid !== expSame) begin errors++; $display("[TB] FAIL single_same_cycle_valid got %b want %b", pop_valid, expSame); end
    cycle();
    push_valid = 0;
    checks++; if (pop_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_pop_valid got %b want 1", pop_valid); end
    checks++; if (pop_instr !== 32'h00500093) begin errors++; $display("[TB] FAIL single_pop_instr got %h want 00500093", pop_instr); end
    checks++; if (pop_pc !== 32'h100) begin errors++; $display("[TB] FAIL single_pop_pc got %h want 100", pop_pc); end
    checks++; if (pop_under_shadow !== 1'b1) begin errors++; $display("[TB] FAIL single_pop_shadow got %b want 1", pop_under_shadow); end
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL single_count got %0d want 1", count); end
    pop_ready = 1;
    cycle();
    pop_ready = 0;
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL single_drain_count got %0d want 0", count); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain_valid got %b want 0", pop_valid); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      push_valid = 1; push_instr = 32'h1000 + i; push_pc = 32'h200 + 4 * i; push_under_shadow = i[0];
      cycle();
    end
    checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL fill_count got %0d want 8", count); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_push_ready got %b want 0", push_ready); end
    push_instr = 32'hDEAD_BEEF; push_pc = 32'hFFF0; push_under_shadow = 1;
    cycle();
    push_valid = 0;
    checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL overflow_count got %0d want 8", count); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({pop_valid, pop_instr, pop_pc, pop_under_shadow} !== {1'b1, 32'h1000 + i, 32'h200 + 4 * i, i[0]}) begin
        errors++;
        $display("[TB] FAIL drain_entry%0d got v=%b %h %h %b want v=1 %h %h %b", i, pop_valid, pop_instr, pop_pc,
                 pop_under_shadow, 32'h1000 + i, 32'h200 + 4 * i, i[0]);
      end
      pop_ready = 1;
      cycle();
    end
    pop_ready = 0;
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL drain_count got %0d want 0", count); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_pop_valid got %b want 0", pop_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] model[$];
    logic [31:0] nextVal;
    nextVal = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1; push_instr = nextVal; push_pc = ~nextVal; push_under_shadow = nextVal[0];
      model.push_back(nextVal);
      nextVal++;
      cycle();
    end
    for (int i = 0; i < 20; i++) begin
      checks++; if (count !== 4'd4) begin errors++; $display("[TB] FAIL b2b_count%0d got %0d want 4", i, count); end
      checks++;
      if ({pop_instr, pop_pc} !== {model[0], ~model[0]}) begin
        errors++; $display("[TB] FAIL b2b_head%0d got %h/%h want %h/%h", i, pop_instr, pop_pc, model[0], ~model[0]);
      end
      push_valid = 1; pop_ready = 1;
      push_instr = nextVal; push_pc = ~nextVal; push_under_shadow = nextVal[0];
      model.push_back(nextVal);
      void'(model.pop_front());
      nextVal++;
      cycle();
    end
    push_valid = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({pop_valid, pop_instr, pop_under_shadow} !== {1'b1, model[0], model[0][0]}) begin
        errors++; $display("[TB] FAIL b2b_drain%0d got %b %h %b want 1 %h %b", i, pop_valid, pop_instr, pop_under_shadow,
                           model[0], model[0][0]);
      end
      void'(model.pop_front());
      cycle();
    end
    pop_ready = 0;
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL b2b_end_count got %0d want 0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      push_valid = 1; push_instr = 32'h4000 + i; push_pc = 32'h400 + 4 * i; push_under_shadow = 0;
      cycle();
    end
    checks++; if (count !== 4'd5) begin errors++; $display("[TB] FAIL flush_pre_count got %0d want 5", count); end
    flush = 1; push_valid = 1; pop_ready = 1; push_instr = 32'h0BAD_0BAD; push_pc = 32'h999;
    cycle();
    flush = 0; push_valid = 0; pop_ready = 0;
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL flush_count got %0d want 0", count); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_pop_valid got %b want 0", pop_valid); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_push_ready got %b want 1", push_ready); end
    push_valid = 1; push_instr = 32'h5555_0001; push_pc = 32'h500; push_under_shadow = 1;
    cycle();
    push_valid = 0;
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL post_flush_count got %0d want 1", count); end
    checks++;
    if ({pop_instr, pop_pc} !== {32'h5555_0001, 32'h500}) begin
      errors++; $display("[TB] FAIL post_flush_head got %h/%h want 55550001/500", pop_instr, pop_pc);
    end
  endtask

  task automatic test_reset_flush();
    push_valid = 1; push_instr = 32'h6666_6666; push_pc = 32'h600; push_under_shadow = 1;
    cycle();
    rst = 1; flush = 1; pop_ready = 1; push_instr = 32'h7777_7777; push_pc = 32'h700;
    cycle();
    idleInputs();
    checks++; if (push_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstflush_push_ready got %b want 1", push_ready); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstflush_pop_valid got %b want 0", pop_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL rstflush_count got %0d want 0", count); end
    checks++;
    if ({pop_instr, pop_pc, pop_under_shadow} !== 65'd0) begin
      errors++; $display("[TB] FAIL rstflush_head got %h/%h/%b want 0/0/0", pop_instr, pop_pc, pop_under_shadow);
    end
  endtask

  task automatic test_random();
    logic [64:0] model[$];
    logic [64:0] entry;
    logic        doPush;
    logic        doPop;
    for (int i = 0; i < 10000; i++) begin
      checks++;
      if (count !== 4'(model.size())) begin
        errors++; $display("[TB] FAIL rand_count@%0d got %0d want %0d", i, count, model.size());
      end
      checks++;
      if ({pop_valid, push_ready} !== {model.size() != 0, model.size() < 8}) begin
        errors++; $display("[TB] FAIL rand_flags@%0d got pv=%b pr=%b want pv=%b pr=%b", i, pop_valid, push_ready,
                           model.size() != 0, model.size() < 8);
      end
      if (model.size() != 0) begin
        checks++;
        if ({pop_instr, pop_pc, pop_under_shadow} !== model[0]) begin
          errors++; $display("[TB] FAIL rand_head@%0d got %h want %h", i, {pop_instr, pop_pc, pop_under_shadow}, model[0]);
        end
      end
      push_valid = ($urandom_range(0, 99) < 55);
      pop_ready  = ($urandom_range(0, 99) < 50);
      flush      = ($urandom_range(0, 99) < 2);
      entry      = {$urandom(), $urandom(), 1'($urandom())};
      push_instr = entry[64:33]; push_pc = entry[32:1]; push_under_shadow = entry[0];
      doPush = push_valid && (model.size() < 8);
      doPop  = pop_ready && (model.size() != 0);
      if (flush) begin
        model.delete();
      end else begin
        if (doPop) void'(model.pop_front());
        if (doPush) model.push_back(entry);
      end
      cycle();
    end
    idleInputs();
  endtask

  initial begin
    idleInputs();
    @(negedge clk);
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_reset_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
